// File: rtl/syn_ps_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional saturating stall counter output enabled by `define SYN_PS_STALL_CNT_EN.
module syn_ps_skid #(
  parameter int               DATA_W     = 32,
  parameter int               REG_W      = 5,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              regfile_w_en_in,
  input  logic [REG_W-1:0]  regfile_req_w_in,
  input  logic              r_datamem_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data,
  output logic              regfile_w_en,
  output logic [REG_W-1:0]  regfile_req_w,
  output logic              r_datamem
`ifdef SYN_PS_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              w_en;
    logic [REG_W-1:0]  idx;
    logic              rd;
  } payload_t;

  localparam payload_t P_RST = {RESET_DATA, 1'b0, {REG_W{1'b0}}, 1'b0};

  state_t   r_state;
  state_t   w_next_state;
  payload_t r_m;
  payload_t r_s;
  payload_t w_in;
  logic     w_accept;
  logic     w_take;
  logic     w_load_m_in;
  logic     w_load_m_skid;
  logic     w_load_s;

  assign w_in     = {data_in, regfile_w_en_in, regfile_req_w_in, r_datamem_in};
  assign w_accept = in_valid & in_ready;
  assign w_take   = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_next_state;
  end

  // NOTE: every signal gets a default first so no path through this block infers a latch.
  always_comb begin
    w_next_state  = r_state;
    w_load_m_in   = 1'b0;
    w_load_m_skid = 1'b0;
    w_load_s      = 1'b0;
    if (!clear) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_load_m_in  = 1'b1;
            w_next_state = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_take) begin
            w_load_m_in = 1'b1;
          end else if (w_accept) begin
            w_load_s     = 1'b1;
            w_next_state = ST_TWO;
          end else if (w_take) begin
            w_next_state = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_take) begin
            w_load_m_skid = 1'b1;
            w_next_state  = ST_ONE;
          end
        end
        default: w_next_state = ST_EMPTY;
      endcase
    end
  end

  // Ready depends only on the state flops, so there is no combinational out_ready->in_ready path.
  always_comb begin
    in_ready  = (r_state != ST_TWO);
    out_valid = (r_state != ST_EMPTY);
  end

  // NOTE: payload registers are reset because M drives the outputs, which must show reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m <= P_RST;
      r_s <= P_RST;
    end else if (!clear) begin
      r_m <= P_RST;
      r_s <= P_RST;
    end else begin
      if (w_load_m_in)        r_m <= w_in;
      else if (w_load_m_skid) r_m <= r_s;
      if (w_load_s)           r_s <= w_in;
    end
  end

  assign data          = r_m.data;
  assign regfile_w_en  = r_m.w_en & out_valid;
  assign regfile_req_w = r_m.idx;
  assign r_datamem     = r_m.rd;

`ifdef SYN_PS_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
    end else if (!clear) begin
      r_stall_cnt <= 16'd0;
    end else if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_syn_ps_skid.sv
// Directed self-checking bench for syn_ps_skid: streaming, back-pressure, bubbles, flush, async reset.
// Stall-counter checks compile only when SYN_PS_STALL_CNT_EN is defined.
module tb_syn_ps_skid;

  localparam int          DATA_W = 32;
  localparam int          REG_W  = 5;
  localparam logic [31:0] RST_D  = 32'hDEAD_BEEF;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic              regfile_w_en_in;
  logic [REG_W-1:0]  regfile_req_w_in;
  logic              r_datamem_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data;
  logic              regfile_w_en;
  logic [REG_W-1:0]  regfile_req_w;
  logic              r_datamem;
`ifdef SYN_PS_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  syn_ps_skid #(
    .DATA_W    (DATA_W),
    .REG_W     (REG_W),
    .RESET_DATA(RST_D)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (clear),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .data_in         (data_in),
    .regfile_w_en_in (regfile_w_en_in),
    .regfile_req_w_in(regfile_req_w_in),
    .r_datamem_in    (r_datamem_in),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .data            (data),
    .regfile_w_en    (regfile_w_en),
    .regfile_req_w   (regfile_req_w),
    .r_datamem       (r_datamem)
`ifdef SYN_PS_STALL_CNT_EN
    ,
    .stall_cnt       (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic we,
                       input logic [4:0] idx, input logic rd);
    in_valid         = v;
    data_in          = d;
    regfile_w_en_in  = we;
    regfile_req_w_in = idx;
    r_datamem_in     = rd;
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_data", data, RST_D);
    check("rst_wen", regfile_w_en, 0);
    check("rst_idx", regfile_req_w, 0);
    check("rst_rd", r_datamem, 0);
    rst_n = 1'b1;
    tick();

    // Streaming: 1,2,3,4 back to back with the sink always ready.
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i, 1'b1, 5'(i + 2), 1'b0);
      tick();
      check($sformatf("stream_valid_%0d", i), out_valid, 1);
      check($sformatf("stream_data_%0d", i), data, i);
      check($sformatf("stream_idx_%0d", i), regfile_req_w, i + 2);
      check($sformatf("stream_wen_%0d", i), regfile_w_en, 1);
      check($sformatf("stream_rdy_%0d", i), in_ready, 1);
    end
    drive(1'b0, 32'd0, 1'b1, 5'd0, 1'b0);
    tick();
    check("stream_drain_valid", out_valid, 0);
    check("stale_wen_masked", regfile_w_en, 0);

    // Back-pressure: A then B with the sink stalled; C offered while full must wait.
    out_ready = 1'b0;
    drive(1'b1, 32'hAA, 1'b1, 5'd1, 1'b0);
    tick();
    check("bp_a_data", data, 32'hAA);
    check("bp_a_rdy", in_ready, 1);
    drive(1'b1, 32'hBB, 1'b0, 5'd7, 1'b1);
    tick();
    check("bp_two_rdy", in_ready, 0);
    check("bp_two_data", data, 32'hAA);
    check("bp_two_valid", out_valid, 1);
    drive(1'b1, 32'hCC, 1'b1, 5'd9, 1'b0);
    tick();
    check("bp_hold_data", data, 32'hAA);
    check("bp_hold_wen", regfile_w_en, 1);
    check("bp_hold_rdy", in_ready, 0);
    out_ready = 1'b1;
    tick();
    check("bp_b_data", data, 32'hBB);
    check("bp_b_idx", regfile_req_w, 7);
    check("bp_b_rd", r_datamem, 1);
    check("bp_b_wen", regfile_w_en, 0);
    check("bp_b_rdy", in_ready, 1);
    tick();
    check("bp_c_data", data, 32'hCC);
    check("bp_c_idx", regfile_req_w, 9);
    drive(1'b0, 32'd0, 1'b1, 5'd0, 1'b0);
    tick();
    check("bp_empty_valid", out_valid, 0);

    // Bubbles: enable asserted on input but nothing valid.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h1234 + i, 1'b1, 5'd3, 1'b1);
      tick();
      check($sformatf("bubble_wen_%0d", i), regfile_w_en, 0);
      check($sformatf("bubble_valid_%0d", i), out_valid, 0);
    end

    // Flush while full, with a same-cycle beat and take both discarded.
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 1'b1, 5'd2, 1'b1);
    tick();
    drive(1'b1, 32'h22, 1'b1, 5'd4, 1'b1);
    tick();
    check("fl_pre_rdy", in_ready, 0);
    clear     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h55, 1'b1, 5'd5, 1'b1);
    tick();
    check("fl_valid", out_valid, 0);
    check("fl_data", data, RST_D);
    check("fl_wen", regfile_w_en, 0);
    check("fl_idx", regfile_req_w, 0);
    check("fl_rd", r_datamem, 0);
    check("fl_rdy", in_ready, 1);
    clear = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    tick();
    check("fl_no_ghost", out_valid, 0);

    // Async reset while full, asserted mid-cycle.
    out_ready = 1'b0;
    drive(1'b1, 32'h33, 1'b1, 5'd6, 1'b1);
    tick();
    drive(1'b1, 32'h44, 1'b1, 5'd8, 1'b0);
    tick();
    check("ar_pre_rdy", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_rdy", in_ready, 1);
    check("ar_data", data, RST_D);
    check("ar_idx", regfile_req_w, 0);
    check("ar_rd", r_datamem, 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h77, 1'b1, 5'd10, 1'b0);
    tick();
    check("ar_post_data", data, 32'h77);
    check("ar_post_valid", out_valid, 1);
    check("ar_post_wen", regfile_w_en, 1);
    drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    tick();
    check("ar_post_drain", out_valid, 0);

`ifdef SYN_PS_STALL_CNT_EN
    check("sc_start", stall_cnt, 0);
    out_ready = 1'b0;
    drive(1'b1, 32'h99, 1'b1, 5'd1, 1'b0);
    tick();
    drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    tick();
    check("sc_one", stall_cnt, 1);
    repeat (70000) @(posedge clk);
    #1;
    check("sc_sat", stall_cnt, 16'hFFFF);
    clear = 1'b0;
    tick();
    check("sc_clear", stall_cnt, 0);
    clear = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
